// File: rtl/iterative_normalizer.sv
// Purpose: multi-cycle left-normalizer; shifts a word left until its MSB is 1 and reports the shift.
// Latency: operand 0 -> 1 cycle; otherwise LZ/4 + LZ%4 + 3 cycles from accept to valid_o.
// Backpressure: result held stable in DONE until ready_i; ready_o low while busy (no overlap).
//
// Ports:
//   clk_i, rst_n_i             clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o          operand handshake; ready_o is high only in IDLE
//   operand_i                  word to normalize
//   valid_o / ready_i          result handshake; valid_o is high only in DONE
//   normalized_o               operand << shift_count_o (zero outside DONE)
//   shift_count_o              leading zeros removed (zero outside DONE)
//   is_all_zero_o              operand was all zero (zero outside DONE)
//
// DATA_WIDTH must be 24 or 32 (a multiple of 4, so the nibble steps tile the word).

module iterative_normalizer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         normalized_o,
  output logic [$clog2(DATA_WIDTH)-1:0] shift_count_o,
  output logic                          is_all_zero_o
);

  localparam int CW  = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NIBBLE = 2'd1,
    S_BIT    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_zero;
  logic                  w_zero_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_data_nxt   = r_data;
    w_count_nxt  = r_count;
    w_zero_nxt   = r_zero;

    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_count_nxt = '0;
          if (operand_i == '0) begin
            // A zero word can never be normalized; report it directly.
            w_data_nxt   = '0;
            w_zero_nxt   = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_data_nxt   = operand_i;
            w_zero_nxt   = 1'b0;
            w_next_state = S_NIBBLE;
          end
        end
      end

      S_NIBBLE: begin
        // Data is non-zero here, so this loop always terminates.
        if (r_data[MSB-:4] == 4'b0000) begin
          w_data_nxt  = r_data << 4;
          w_count_nxt = r_count + CW'(4);
        end else begin
          w_next_state = S_BIT;
        end
      end

      S_BIT: begin
        // At most three fine steps remain after the nibble phase.
        if (!r_data[MSB]) begin
          w_data_nxt  = r_data << 1;
          w_count_nxt = r_count + CW'(1);
        end else begin
          w_next_state = S_DONE;
        end
      end

      S_DONE: begin
        if (ready_i) begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);

  // Gate results so intermediate shift states are never visible.
  assign normalized_o  = valid_o ? r_data  : '0;
  assign shift_count_o = valid_o ? r_count : '0;
  assign is_all_zero_o = valid_o ? r_zero  : 1'b0;

endmodule

// File: tb/tb_iterative_normalizer.sv
module tb_iterative_normalizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        vi32, ri32, ro32, vo32, z32;
  logic [31:0] op32, no32;
  logic [4:0]  sc32;
  // 24-bit instance
  logic        vi24, ri24, ro24, vo24, z24;
  logic [23:0] op24, no24;
  logic [4:0]  sc24;

  iterative_normalizer #(.DATA_WIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(vi32), .ready_o(ro32),
    .operand_i(op32), .valid_o(vo32), .ready_i(ri32),
    .normalized_o(no32), .shift_count_o(sc32), .is_all_zero_o(z32)
  );

  iterative_normalizer #(.DATA_WIDTH(24)) dut24 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(vi24), .ready_o(ro24),
    .operand_i(op24), .valid_o(vo24), .ready_i(ri24),
    .normalized_o(no24), .shift_count_o(sc24), .is_all_zero_o(z24)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference leading-zero count over the low w bits (w when all zero).
  function automatic int ref_lz(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return w - 1 - i;
    end
    return w;
  endfunction

  // Issue one operand, wait (bounded) for valid_o, compare latency and results.
  task automatic run_op(input bit w24, input logic [31:0] op, input logic [31:0] norm,
                        input logic [4:0] cnt, input logic zero, input int lat,
                        input string tag);
    int cyc;
    @(negedge clk);
    check({tag, "_ready_idle"}, {31'b0, (w24 ? ro24 : ro32)}, 32'd1);
    if (w24) begin vi24 = 1'b1; op24 = op[23:0]; end
    else     begin vi32 = 1'b1; op32 = op;       end
    @(posedge clk);
    #1;
    vi32 = 1'b0;
    vi24 = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_ready_busy"}, {31'b0, (w24 ? ro24 : ro32)}, 32'd0);
      if (w24 ? vo24 : vo32) begin
        cyc = c;
        break;
      end
    end
    check({tag, "_latency"}, cyc, lat);
    if (cyc != 0) begin
      check({tag, "_norm"}, w24 ? {8'b0, no24} : no32, norm);
      check({tag, "_cnt"},  {27'b0, (w24 ? sc24 : sc32)}, {27'b0, cnt});
      check({tag, "_zero"}, {31'b0, (w24 ? z24 : z32)}, {31'b0, zero});
    end
  endtask

  typedef struct {
    bit          w24;
    logic [31:0] op;
    logic [31:0] norm;
    logic [4:0]  cnt;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, nrm;
    int          lz, lat;
    logic [31:0] hold_n;
    logic [4:0]  hold_c;
    bit          seen;

    tbl[0]  = '{0, 32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0, 3};
    tbl[1]  = '{0, 32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0, 13};
    tbl[2]  = '{0, 32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0, 9};
    tbl[3]  = '{0, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b1, 1};
    tbl[4]  = '{0, 32'h0F00_0000, 32'hF000_0000, 5'd4,  1'b0, 4};
    tbl[5]  = '{0, 32'h4000_0000, 32'h8000_0000, 5'd1,  1'b0, 4};
    tbl[6]  = '{0, 32'h0030_0000, 32'hC000_0000, 5'd10, 1'b0, 7};
    tbl[7]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b0, 3};
    tbl[8]  = '{1, 32'h0000_0001, 32'h0080_0000, 5'd23, 1'b0, 11};
    tbl[9]  = '{1, 32'h0080_0000, 32'h0080_0000, 5'd0,  1'b0, 3};
    tbl[10] = '{1, 32'h0001_2345, 32'h0091_A280, 5'd7,  1'b0, 7};

    rst_n = 1'b0;
    vi32 = 1'b0; ri32 = 1'b1; op32 = '0;
    vi24 = 1'b0; ri24 = 1'b1; op24 = '0;
    #3;
    check("rst_ready",  {31'b0, ro32}, 32'd1);
    check("rst_valid",  {31'b0, vo32}, 32'd0);
    check("rst_norm",   no32, 32'd0);
    check("rst_cnt",    {27'b0, sc32}, 32'd0);
    check("rst_zero",   {31'b0, z32}, 32'd0);
    check("rst_ready24", {31'b0, ro24}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].w24, tbl[i].op, tbl[i].norm, tbl[i].cnt, tbl[i].zero, tbl[i].lat,
             $sformatf("vec%0d", i));
    end

    // Reset dropped while the 32-bit unit is in its nibble phase
    @(negedge clk);
    vi32 = 1'b1; op32 = 32'h0000_0001;
    @(posedge clk);
    #1 vi32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_ready", {31'b0, ro32}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", {31'b0, ro32}, 32'd1);
    check("abort_valid", {31'b0, vo32}, 32'd0);
    check("abort_norm",  no32, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (vo32) seen = 1'b1;
    end
    check("abort_no_result", {31'b0, seen}, 32'd0);

    // Back-pressure: result must hold while ready_i is low, new valid_i ignored
    ri32 = 1'b0;
    run_op(1'b0, 32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0, 9, "bp");
    hold_n = 32'h91A2_8000;
    hold_c = 5'd15;
    for (int i = 0; i < 5; i++) begin
      vi32 = 1'b1;
      op32 = $urandom | 32'h1;
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), {31'b0, vo32}, 32'd1);
      check($sformatf("bp_hold_ready%0d", i), {31'b0, ro32}, 32'd0);
      check($sformatf("bp_hold_norm%0d", i),  no32, hold_n);
      check($sformatf("bp_hold_cnt%0d", i),   {27'b0, sc32}, {27'b0, hold_c});
    end
    vi32 = 1'b0;
    ri32 = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'b0, vo32}, 32'd0);
    check("bp_release_ready", {31'b0, ro32}, 32'd1);
    repeat (3) @(negedge clk);
    check("bp_no_ghost", {31'b0, vo32}, 32'd0);

    // Random sweep against the reference leading-zero count
    for (int i = 0; i < 30; i++) begin
      v   = $urandom >> $urandom_range(0, 31);
      lz  = ref_lz(v, 32);
      nrm = (lz == 32) ? 32'd0 : (v << lz);
      lat = (lz == 32) ? 1 : (lz / 4 + lz % 4 + 3);
      run_op(1'b0, v, nrm, (lz == 32) ? 5'd0 : 5'(lz), (lz == 32), lat,
             $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      v   = ($urandom & 32'h00FF_FFFF) >> $urandom_range(0, 23);
      lz  = ref_lz(v, 24);
      nrm = (lz == 24) ? 32'd0 : ((v << lz) & 32'h00FF_FFFF);
      lat = (lz == 24) ? 1 : (lz / 4 + lz % 4 + 3);
      run_op(1'b1, v, nrm, (lz == 24) ? 5'd0 : 5'(lz), (lz == 24), lat,
             $sformatf("rnd24_%0d", i));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
